// File: rtl/core_pkg.sv
// Shared integer-core constants: data width, register-file geometry and
// the fixed mapping of execution units onto write-back source indices.
package core_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam int SRC_ALU = 0;
   localparam int SRC_MUL = 1;
   localparam int SRC_LSU = 2;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Width of a pointer that selects one of n requesters (never zero-width).
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping around, and reports the pointer to use after this grant.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int PTR_W = core_pkg::ptr_width(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] ptr_next
);

   int   base;
   logic found;

   // Two passes: requesters from base upward, then the ones that wrapped.
   always_comb begin
      grant    = '0;
      ptr_next = ptr;
      found    = 1'b0;
      base     = (int'(ptr) >= N) ? 0 : int'(ptr);
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i >= base)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_next = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!found && req[i] && (i < base)) begin
            grant[i] = 1'b1;
            found    = 1'b1;
            ptr_next = (i == N - 1) ? '0 : PTR_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/writeback_scoreboard.sv
// Register-file write-back: busy scoreboard with RAW/WAW issue stall and a
// round-robin arbiter merging execution results onto the single write port.
module writeback_scoreboard #(
   parameter int NUM_SRC = 3,
   parameter int XLEN    = core_pkg::XLEN
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          iss_valid_i,
   input  logic [core_pkg::REG_ADDR_W-1:0]               iss_rs1_i,
   input  logic [core_pkg::REG_ADDR_W-1:0]               iss_rs2_i,
   input  logic [core_pkg::REG_ADDR_W-1:0]               iss_rd_i,
   input  logic                                          iss_rd_wr_i,
   output logic                                          iss_stall_o,
   input  logic [NUM_SRC-1:0]                            res_valid_i,
   input  logic [NUM_SRC-1:0][core_pkg::REG_ADDR_W-1:0]  res_rd_i,
   input  logic [NUM_SRC-1:0][XLEN-1:0]                  res_data_i,
   output logic [NUM_SRC-1:0]                            res_ready_o,
   output logic [core_pkg::REG_ADDR_W-1:0]               rd_addr_o,
   output logic                                          wr_en_o,
   output logic [XLEN-1:0]                               wr_data_o,
   output logic [core_pkg::NUM_REGS-1:0]                 busy_o,
   output logic                                          err_o
);

   import core_pkg::*;

   localparam int PTR_W = ptr_width(NUM_SRC);

   // x0 has no storage; it reads as not-busy through busy_vec.
   logic [NUM_REGS-1:1] busy_q, busy_d;
   logic [NUM_REGS-1:0] busy_vec;
   logic [PTR_W-1:0]    ptr_q, ptr_next;
   logic [NUM_SRC-1:0]  grant;
   logic                transfer, accept, set_en, err_hit;
   reg_addr_t           sel_rd;
   logic [XLEN-1:0]     sel_data;

   assign busy_vec = {busy_q, 1'b0};
   assign busy_o   = busy_vec;

   assign iss_stall_o = iss_valid_i &&
                        (busy_vec[iss_rs1_i] || busy_vec[iss_rs2_i] ||
                         (iss_rd_wr_i && busy_vec[iss_rd_i]));
   assign accept = iss_valid_i && !iss_stall_o;
   assign set_en = accept && iss_rd_wr_i && (iss_rd_i != '0);

   rr_arbiter #(
      .N     (NUM_SRC),
      .PTR_W (PTR_W)
   ) u_arb (
      .req      (res_valid_i),
      .ptr      (ptr_q),
      .grant    (grant),
      .ptr_next (ptr_next)
   );

   assign res_ready_o = grant;
   assign transfer    = |(grant & res_valid_i);

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (grant[s]) begin
            sel_rd   = res_rd_i[s];
            sel_data = res_data_i[s];
         end
      end
   end

   // A write to a register nobody is waiting on means a lost or duplicated result.
   assign err_hit = transfer && (sel_rd != '0) && !busy_vec[sel_rd];

   // Clear is applied first so a same-cycle set on that index wins.
   always_comb begin
      busy_d = busy_q;
      for (int r = 1; r < NUM_REGS; r++) begin
         if (wr_en_o && (rd_addr_o == REG_ADDR_W'(r))) busy_d[r] = 1'b0;
         if (set_en && (iss_rd_i == REG_ADDR_W'(r)))   busy_d[r] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q    <= '0;
         ptr_q     <= '0;
         rd_addr_o <= '0;
         wr_en_o   <= 1'b0;
         wr_data_o <= '0;
         err_o     <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         wr_en_o <= transfer && (sel_rd != '0);
         if (transfer) begin
            ptr_q     <= ptr_next;
            rd_addr_o <= sel_rd;
            wr_data_o <= sel_data;
         end
         if (err_hit) err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_writeback_scoreboard.sv
// Self-checking bench: queue-based source/issue model predicts stall, grant,
// busy and error per cycle; a monitor matches write-backs against a queue.
module tb_writeback_scoreboard;

   import core_pkg::*;

   localparam int NS = 3;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } res_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 iss_valid, iss_rd_wr, iss_stall;
   logic [4:0]           iss_rs1, iss_rs2, iss_rd;
   logic [NS-1:0]        res_valid, res_ready;
   logic [NS-1:0][4:0]   res_rd;
   logic [NS-1:0][63:0]  res_data;
   logic [4:0]           rd_addr;
   logic                 wr_en, err;
   logic [63:0]          wr_data;
   logic [31:0]          busy;

   always #5 clk = ~clk;

   writeback_scoreboard #(.NUM_SRC(NS), .XLEN(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .iss_valid_i (iss_valid),
      .iss_rs1_i   (iss_rs1),
      .iss_rs2_i   (iss_rs2),
      .iss_rd_i    (iss_rd),
      .iss_rd_wr_i (iss_rd_wr),
      .iss_stall_o (iss_stall),
      .res_valid_i (res_valid),
      .res_rd_i    (res_rd),
      .res_data_i  (res_data),
      .res_ready_o (res_ready),
      .rd_addr_o   (rd_addr),
      .wr_en_o     (wr_en),
      .wr_data_o   (wr_data),
      .busy_o      (busy),
      .err_o       (err)
   );

   res_t        src_q[NS][$];
   res_t        exp_q[$];
   int          grant_log[$];
   bit          present[NS];
   bit [31:0]   busy_m;
   int          ptr_m;
   bit          err_m, clr_v, last_accept, rand_present, auto_res;
   logic [4:0]  clr_a;
   int          checks = 0;
   int          failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      busy_m = '0;
      ptr_m  = 0;
      err_m  = 1'b0;
      clr_v  = 1'b0;
      for (int s = 0; s < NS; s++) begin
         src_q[s].delete();
         present[s] = 1'b0;
      end
      exp_q.delete();
   endtask

   task automatic set_iss(input bit v, input int rs1, input int rs2, input int rd, input bit wr);
      iss_valid = v;
      iss_rs1   = 5'(rs1);
      iss_rs2   = 5'(rs2);
      iss_rd    = 5'(rd);
      iss_rd_wr = wr;
   endtask

   task automatic push_res(input int s, input int rd, input logic [63:0] data);
      res_t r;
      r.rd   = 5'(rd);
      r.data = data;
      src_q[s].push_back(r);
   endtask

   task automatic drive_sources();
      for (int s = 0; s < NS; s++) begin
         if (!present[s] && src_q[s].size() > 0 && (!rand_present || $urandom_range(0, 2) != 0))
            present[s] = 1'b1;
         res_valid[s] = present[s];
         if (present[s]) begin
            res_rd[s]   = src_q[s][0].rd;
            res_data[s] = src_q[s][0].data;
         end
      end
   endtask

   // One clock: present stimulus, check combinational/registered outputs at the
   // falling edge, then advance the reference model to the next cycle.
   task automatic step();
      res_t          r;
      int            g;
      bit            exp_stall, acc;
      logic [NS-1:0] exp_ready;
      drive_sources();
      @(negedge clk);
      exp_stall = iss_valid && (busy_m[iss_rs1] || busy_m[iss_rs2] || (iss_rd_wr && busy_m[iss_rd]));
      g = -1;
      for (int k = 0; k < NS; k++) begin
         if (g < 0 && present[(ptr_m + k) % NS]) g = (ptr_m + k) % NS;
      end
      exp_ready = (g >= 0) ? NS'(1 << g) : '0;
      check("stall", iss_stall, exp_stall);
      check("ready", res_ready, exp_ready);
      check("busy", busy, busy_m);
      check("err", err, err_m);
      check("wr_en", wr_en, clr_v);
      acc = iss_valid && !exp_stall;
      r.rd = '0;
      r.data = '0;
      if (g >= 0) begin
         r = src_q[g].pop_front();
         present[g] = 1'b0;
         ptr_m = (g + 1) % NS;
         grant_log.push_back(g);
         if (r.rd != 0 && !busy_m[r.rd]) err_m = 1'b1;
         if (r.rd != 0) exp_q.push_back(r);
      end
      if (clr_v) busy_m[clr_a] = 1'b0;
      clr_v = (g >= 0) && (r.rd != 0);
      clr_a = r.rd;
      if (acc && iss_rd_wr && iss_rd != 0) busy_m[iss_rd] = 1'b1;
      if (acc && iss_rd_wr && auto_res)
         push_res($urandom_range(0, NS - 1), int'(iss_rd), {$urandom, $urandom});
      last_accept = acc;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      set_iss(0, 0, 0, 0, 0);
      res_valid = '0;
      res_rd    = '0;
      res_data  = '0;
      model_clear();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Write-back monitor: every wr_en cycle must match the oldest expected result.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (!reset && wr_en) begin
            if (exp_q.size() == 0) begin
               check("wb_unexpected", {59'd0, rd_addr}, 64'hffff_ffff_ffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("wb_rd", rd_addr, e.rd);
               check("wb_data", wr_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rand_present = 1'b0;
      auto_res     = 1'b0;
      last_accept  = 1'b0;
      do_reset();
      check("rst_busy", busy, 32'd0);
      check("rst_wr_en", wr_en, 1'b0);
      check("rst_rd_addr", rd_addr, 5'd0);
      check("rst_wr_data", wr_data, 64'd0);
      check("rst_err", err, 1'b0);

      // RAW: x5 written, reader stalls until the cycle after write-back.
      set_iss(1, 0, 0, 5, 1);
      step();
      check("busy5_set", busy[5], 1'b1);
      set_iss(1, 5, 0, 0, 0);
      push_res(SRC_ALU, 5, 64'h1234);
      step();
      step();
      check("stall_drop", iss_stall, 1'b0);
      step();
      check("raw_accept", last_accept, 1'b1);
      set_iss(0, 0, 0, 0, 0);
      step();

      // Contention: all three sources valid from ptr=0.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_iss(1, 0, 0, 10 + i, 1);
         step();
      end
      set_iss(0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) push_res(i % NS, 10 + i, 64'(100 + i));
      grant_log.delete();
      repeat (8) step();
      for (int i = 0; i < 6; i++) check("rr_order", grant_log[i], i % NS);

      // x0 destination: no busy change, no stall, no write, no error.
      set_iss(1, 0, 0, 0, 1);
      step();
      set_iss(0, 0, 0, 0, 0);
      push_res(SRC_MUL, 0, 64'hdead);
      repeat (3) step();

      // Unexpected result to x7 raises the sticky error; the write still lands.
      push_res(SRC_LSU, 7, 64'habc);
      step();
      step();
      check("err_set", err, 1'b1);
      step();
      check("err_sticky", err, 1'b1);

      // WAW on x9.
      set_iss(1, 0, 0, 9, 1);
      step();
      repeat (3) step();
      push_res(SRC_MUL, 9, 64'h99);
      n = 0;
      do begin
         step();
         n++;
      end while (!last_accept && n < 10);
      check("waw_accept", last_accept, 1'b1);
      set_iss(0, 0, 0, 0, 0);
      push_res(SRC_ALU, 9, 64'h999);
      repeat (3) step();

      // Reset with x3 busy and a write-back in progress.
      set_iss(1, 0, 0, 3, 1);
      step();
      set_iss(1, 0, 0, 4, 1);
      step();
      set_iss(0, 0, 0, 0, 0);
      push_res(SRC_MUL, 4, 64'h44);
      step();
      check("pre_rst_wr_en", wr_en, 1'b1);
      check("pre_rst_busy3", busy[3], 1'b1);
      reset = 1'b1;
      #1;
      check("midrst_busy", busy, 32'd0);
      check("midrst_wr_en", wr_en, 1'b0);
      check("midrst_err", err, 1'b0);
      model_clear();
      res_valid = '0;
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) push_res(s, 0, 64'(s));
      grant_log.delete();
      repeat (4) step();
      check("ptr_after_rst", grant_log[0], SRC_ALU);

      // Randomized traffic with hazards on a small register window.
      do_reset();
      rand_present = 1'b1;
      auto_res     = 1'b1;
      for (int c = 0; c < 500; c++) begin
         if (!iss_valid || last_accept) begin
            if ($urandom_range(0, 9) < 7)
               set_iss(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                       $urandom_range(0, 4) != 0);
            else
               set_iss(0, 0, 0, 0, 0);
         end
         step();
      end
      set_iss(0, 0, 0, 0, 0);
      n = 0;
      while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + exp_q.size() > 0 || clr_v)
             && n < 300) begin
         step();
         n++;
      end
      check("drain_empty", exp_q.size() + src_q[0].size() + src_q[1].size() + src_q[2].size(), 0);
      check("final_busy", busy, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
